// File: rtl/adder_result_collector.sv
// adder_result_collector: captures result bytes from a producer with no
// backpressure into a DEPTH-entry FIFO for a host reader. It counts the
// accepted results, closes after EXPECTED of them, and reports done once the
// FIFO has drained.
// Optional feature macro: COLLECTOR_CHECKSUM_EN adds checksum_o, a running
// modulo-2^16 sum of the accepted result bytes.
module adder_result_collector #(
    parameter int DEPTH    = 16,
    parameter int EXPECTED = 2000000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        res_valid_i,
    input  logic [7:0]  res_i,
    output logic        rd_valid_o,
    output logic [7:0]  rd_data_o,
    input  logic        rd_ready_i,
    output logic [31:0] count_o,
    output logic        done_o,
`ifdef COLLECTOR_CHECKSUM_EN
    output logic [15:0] checksum_o,
`endif
    output logic        overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_occ;
    logic [7:0]      r_mem [DEPTH];
    logic [31:0]     r_count;
    logic            r_overflow;

    logic w_accepting;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_count_hit;

    // A full FIFO still takes a push when the reader frees a slot in the
    // same cycle, so a result is only lost when it is full and nobody reads.
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_empty     = (r_occ == '0);
    assign w_full      = (r_occ == OCC_FULL);
    assign w_pop       = !w_empty && rd_ready_i;
    assign w_push      = w_accepting && res_valid_i && (!w_full || w_pop);
    assign w_drop      = w_accepting && res_valid_i && w_full && !w_pop;
    assign w_count_hit = w_push && ((r_count + 32'd1) == 32'(EXPECTED));

    // Head entry is forced to zero while empty so the reset value is visible
    // at once, even though the storage itself is never cleared.
    assign rd_valid_o = !w_empty;
    assign rd_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign done_o     = (r_state == S_DONE);
    assign overflow_o = r_overflow;

    // Next-state logic. IDLE may go straight to FLUSH when the very first
    // accepted result already completes the expected total.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_push) w_state_next = w_count_hit ? S_FLUSH : S_RUN;
            S_RUN:   if (w_count_hit) w_state_next = S_FLUSH;
            S_FLUSH: if (w_empty) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage write; contents are left uninitialised by reset.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= res_i;
    end

    // Accepted-result counter (saturating) and sticky overflow flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef COLLECTOR_CHECKSUM_EN
    logic [15:0] r_checksum;

    assign checksum_o = r_checksum;

    // Running checksum, advanced on the same edge as the counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + {8'h00, res_i};
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Scoreboard testbench for adder_result_collector (DEPTH=16, EXPECTED=20).
// Stimulus pushes the expected read bytes into a queue; a negedge monitor
// pops and compares on every read handshake.
module tb_adder_result_collector;

    localparam int DEPTH    = 16;
    localparam int EXPECTED = 20;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        res_valid_i;
    logic [7:0]  res_i;
    logic        rd_valid_o;
    logic [7:0]  rd_data_o;
    logic        rd_ready_i;
    logic [31:0] count_o;
    logic        done_o;
    logic        overflow_o;
`ifdef COLLECTOR_CHECKSUM_EN
    logic [15:0] checksum_o;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_sum;
    logic [7:0]  last_read;
    logic [7:0]  mon_exp;

    always #5 clk_i = ~clk_i;

    adder_result_collector #(
        .DEPTH    (DEPTH),
        .EXPECTED (EXPECTED)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .res_valid_i (res_valid_i),
        .res_i       (res_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_ready_i  (rd_ready_i),
        .count_o     (count_o),
        .done_o      (done_o),
`ifdef COLLECTOR_CHECKSUM_EN
        .checksum_o  (checksum_o),
`endif
        .overflow_o  (overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read handshake must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!reset_i && rd_valid_o && rd_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected: got %02h expected nothing", rd_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("read data=%02h want=%02h", rd_data_o, mon_exp);
                check("read_data", {24'd0, rd_data_o}, {24'd0, mon_exp});
                last_read = rd_data_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        res_valid_i = 1'b0;
        rd_ready_i  = 1'b0;
        exp_q.delete();
        exp_sum = 16'h0000;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] v, input bit acc);
        res_valid_i = 1'b1;
        res_i       = v;
        if (acc) begin
            exp_q.push_back(v);
            exp_sum = exp_sum + {8'h00, v};
        end
        $display("push data=%02h accept=%0d", v, acc);
        tick();
        res_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_ready_i = 1'b1;
        while (rd_valid_o && n < 64) begin
            tick();
            n++;
        end
        check({name, "_drained"}, {31'd0, rd_valid_o}, 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_csum(input string name, input logic [15:0] exp);
`ifdef COLLECTOR_CHECKSUM_EN
        check(name, {16'd0, checksum_o}, {16'd0, exp});
`endif
    endtask

    initial begin
        reset_i     = 1'b1;
        res_valid_i = 1'b0;
        res_i       = 8'h00;
        rd_ready_i  = 1'b0;
        exp_sum     = 16'h0000;
        last_read   = 8'h00;
        tick();
        tick();
        reset_i = 1'b0;

        // Reset state.
        check("rst_count", count_o, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_overflow", {31'd0, overflow_o}, 32'd0);
        check_csum("rst_checksum", 16'h0000);

        // Ordered stream with reader ready; one-cycle visibility latency.
        rd_ready_i = 1'b1;
        push(8'h03, 1'b1);
        check("latency_rd_valid", {31'd0, rd_valid_o}, 32'd1);
        check("latency_rd_data", {24'd0, rd_data_o}, 32'h03);
        push(8'h05, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h01, 1'b1);
        drain("stream");
        check("stream_count", count_o, 32'd4);
        check("stream_done", {31'd0, done_o}, 32'd0);
        check_csum("stream_checksum", 16'h0108);

        // Overflow: 17 pushes into 16 entries with the reader stalled.
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
        push(8'hEE, 1'b0);
        check("ovf_count", count_o, 32'd16);
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        check("ovf_head", {24'd0, rd_data_o}, 32'h10);
        drain("ovf");
        check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Full FIFO plus simultaneous pop accepts the push; then close out.
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b1);
        check("full_count", count_o, 32'd16);
        check("full_no_ovf", {31'd0, overflow_o}, 32'd0);
        rd_ready_i = 1'b1;
        push(8'hAA, 1'b1);
        check("fullpop_no_ovf", {31'd0, overflow_o}, 32'd0);
        check("fullpop_count", count_o, 32'd17);
        drain("fullpop");
        check("fullpop_last", {24'd0, last_read}, 32'hAA);
        rd_ready_i = 1'b0;
        push(8'h31, 1'b1);
        push(8'h32, 1'b1);
        push(8'h33, 1'b1);
        push(8'h34, 1'b0);
        check("close_count", count_o, 32'd20);
        check("close_no_ovf", {31'd0, overflow_o}, 32'd0);
        check("close_done_early", {31'd0, done_o}, 32'd0);
        check_csum("close_checksum", exp_sum);
        drain("close");
        check("close_done_at_empty", {31'd0, done_o}, 32'd0);
        tick();
        check("close_done", {31'd0, done_o}, 32'd1);
        push(8'h55, 1'b0);
        check("done_ignores_count", count_o, 32'd20);
        check("done_ignores_valid", {31'd0, rd_valid_o}, 32'd0);
        check("done_held", {31'd0, done_o}, 32'd1);

        // Asynchronous reset between edges while FLUSH holds 5 entries.
        do_reset();
        rd_ready_i = 1'b1;
        for (int i = 0; i < 15; i++) push(8'(8'h60 + i), 1'b1);
        tick();
        rd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h80 + i), 1'b1);
        check("flush_count", count_o, 32'd20);
        check("flush_rd_valid", {31'd0, rd_valid_o}, 32'd1);
        #3;
        reset_i = 1'b1;
        exp_q.delete();
        exp_sum = 16'h0000;
        #1;
        check("arst_count", count_o, 32'd0);
        check("arst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("arst_rd_data", {24'd0, rd_data_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_overflow", {31'd0, overflow_o}, 32'd0);
        check_csum("arst_checksum", 16'h0000);
        @(posedge clk_i);
        #3;
        reset_i    = 1'b0;
        rd_ready_i = 1'b1;
        push(8'h99, 1'b1);
        check("post_rst_count", count_o, 32'd1);
        check("post_rst_head", {24'd0, rd_data_o}, 32'h99);
        drain("post_rst");
        check_csum("post_rst_checksum", 16'h0099);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
